// File: rtl/mips_cpu_pkg.sv
// Shared types for the MIPS memory-access stage: load/store opcodes, FSM states, lane constants.
package mips_cpu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_LWL = 4'd5,
        OP_LWR = 4'd6,
        OP_SB  = 4'd7,
        OP_SH  = 4'd8,
        OP_SW  = 4'd9
    } mem_op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_RESP  = 2'd3
    } mem_state_t;

    localparam logic [3:0] BE_WORD    = 4'b1111;
    localparam logic [3:0] BE_LO_HALF = 4'b0011;
    localparam logic [3:0] BE_HI_HALF = 4'b1100;
    localparam logic [3:0] BE_LANE0   = 4'b0001;

    function automatic logic is_store(input mem_op_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

endpackage

// File: rtl/mips_cpu_load_align.sv
// Combinational load write-back formatter: lane extraction, sign/zero extension, LWL/LWR merge.
module mips_cpu_load_align
    import mips_cpu_pkg::*;
(
    input  logic [31:0] rdata,
    input  mem_op_t     op,
    input  logic [1:0]  offset,
    input  logic [31:0] rt,
    output logic [31:0] wb_data
);

    logic [31:0] byte_sh;
    logic [15:0] half;
    logic [4:0]  lwl_sh;
    logic [4:0]  lwr_sh;

    always_comb begin
        byte_sh = rdata >> {offset, 3'b000};
        half    = offset[1] ? rdata[31:16] : rdata[15:0];
        lwl_sh  = {2'd3 - offset, 3'b000};
        lwr_sh  = {offset, 3'b000};
        wb_data = '0;
        case (op)
            OP_LB:   wb_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            OP_LBU:  wb_data = {24'h0, byte_sh[7:0]};
            OP_LH:   wb_data = {{16{half[15]}}, half};
            OP_LHU:  wb_data = {16'h0, half};
            OP_LW:   wb_data = rdata;
            // rt keeps the bytes the unaligned fragment does not cover
            OP_LWL:  wb_data = (rdata << lwl_sh) | (rt & ~(32'hFFFF_FFFF << lwl_sh));
            OP_LWR:  wb_data = (rdata >> lwr_sh) | (rt & ~(32'hFFFF_FFFF >> lwr_sh));
            default: wb_data = '0;
        endcase
    end

endmodule

// File: rtl/mips_cpu_mem_stage.sv
// MIPS memory-access stage: one Avalon-MM transfer per request with optional stall timeout.
// Define MIPS_CPU_MEM_ALIGN_CHECK_EN to reject misaligned halfword/word accesses.
//   state    | meaning
//   ST_IDLE  | ready, waiting for req_valid
//   ST_READ  | avm_read held until waitrequest low or timeout
//   ST_WRITE | avm_write held until waitrequest low or timeout
//   ST_RESP  | one-cycle resp_valid pulse
module mips_cpu_mem_stage
    import mips_cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  mem_op_t     req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_dest,
    output logic [31:0] avm_address,
    output logic        avm_read,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    output logic [3:0]  avm_byteenable,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_dest,
    output logic        resp_wen,
    output logic        resp_err
);

    mem_state_t  state_q, state_d;
    mem_op_t     op_q, op_d;
    logic [1:0]  off_q, off_d;
    logic [31:0] rt_q, rt_d;
    logic [4:0]  dest_q, dest_d;
    logic [31:0] tmo_q, tmo_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic [31:0] address_q, address_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] rdata_q, rdata_d;
    logic [4:0]  rdest_q, rdest_d;
    logic        rwen_q, rwen_d;
    logic        rerr_q, rerr_d;

    logic [31:0] load_wb;
    logic [3:0]  req_be;
    logic [31:0] req_steer;
    logic        req_misaligned;

    mips_cpu_load_align u_load_align (
        .rdata   (avm_readdata),
        .op      (op_q),
        .offset  (off_q),
        .rt      (rt_q),
        .wb_data (load_wb)
    );

    always_comb begin
        req_be    = BE_WORD;
        req_steer = req_wdata;
        case (req_op)
            OP_LB, OP_LBU, OP_SB: begin
                req_be    = BE_LANE0 << req_addr[1:0];
                req_steer = {4{req_wdata[7:0]}};
            end
            OP_LH, OP_LHU, OP_SH: begin
                req_be    = req_addr[1] ? BE_HI_HALF : BE_LO_HALF;
                req_steer = {2{req_wdata[15:0]}};
            end
            default: ;
        endcase
`ifdef MIPS_CPU_MEM_ALIGN_CHECK_EN
        case (req_op)
            OP_LH, OP_LHU, OP_SH: req_misaligned = req_addr[0];
            OP_LW, OP_SW:         req_misaligned = |req_addr[1:0];
            default:              req_misaligned = 1'b0;
        endcase
`else
        req_misaligned = 1'b0;
`endif
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        off_d     = off_q;
        rt_d      = rt_q;
        dest_d    = dest_q;
        tmo_d     = tmo_q;
        read_d    = read_q;
        write_d   = write_q;
        address_d = address_q;
        wdata_d   = wdata_q;
        be_d      = be_q;
        rdata_d   = rdata_q;
        rdest_d   = rdest_q;
        rwen_d    = rwen_q;
        rerr_d    = rerr_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    op_d   = req_op;
                    off_d  = req_addr[1:0];
                    rt_d   = req_wdata;
                    dest_d = req_dest;
                    tmo_d  = TIMEOUT_CYCLES;
                    if (req_misaligned) begin
                        state_d = ST_RESP;
                        rdest_d = req_dest;
                        rwen_d  = 1'b0;
                        rerr_d  = 1'b1;
                    end else begin
                        address_d = {req_addr[31:2], 2'b00};
                        be_d      = req_be;
                        wdata_d   = req_steer;
                        if (is_store(req_op)) begin
                            write_d = 1'b1;
                            state_d = ST_WRITE;
                        end else begin
                            read_d  = 1'b1;
                            state_d = ST_READ;
                        end
                    end
                end
            end
            ST_READ, ST_WRITE: begin
                if (!avm_waitrequest) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = ST_RESP;
                    rdest_d = dest_q;
                    rerr_d  = 1'b0;
                    rwen_d  = (state_q == ST_READ);
                    if (state_q == ST_READ) rdata_d = load_wb;
                end else if (TIMEOUT_CYCLES != 0 && tmo_q == 32'd1) begin
                    read_d  = 1'b0;
                    write_d = 1'b0;
                    state_d = ST_RESP;
                    rdest_d = dest_q;
                    rerr_d  = 1'b1;
                    rwen_d  = 1'b0;
                end else begin
                    tmo_d = tmo_q - 32'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_LB;
            off_q     <= '0;
            rt_q      <= '0;
            dest_q    <= '0;
            tmo_q     <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
            address_q <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rdata_q   <= '0;
            rdest_q   <= '0;
            rwen_q    <= 1'b0;
            rerr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            off_q     <= off_d;
            rt_q      <= rt_d;
            dest_q    <= dest_d;
            tmo_q     <= tmo_d;
            read_q    <= read_d;
            write_q   <= write_d;
            address_q <= address_d;
            wdata_q   <= wdata_d;
            be_q      <= be_d;
            rdata_q   <= rdata_d;
            rdest_q   <= rdest_d;
            rwen_q    <= rwen_d;
            rerr_q    <= rerr_d;
        end
    end

    assign req_ready      = (state_q == ST_IDLE);
    assign resp_valid     = (state_q == ST_RESP);
    assign avm_read       = read_q;
    assign avm_write      = write_q;
    assign avm_address    = address_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = be_q;
    assign resp_data      = rdata_q;
    assign resp_dest      = rdest_q;
    assign resp_wen       = rwen_q;
    assign resp_err       = rerr_q;

endmodule

// File: doc/mips_cpu_mem_stage.md
# mips_cpu_mem_stage

Memory-access stage directly downstream of the ALU: takes the effective address the ALU computes for loads and stores (base + sign-extended immediate), runs one Avalon-MM transaction per request with waitrequest stalling, and returns write-back data. It performs byte-lane steering for stores, and extraction and sign/zero extension for loads. It also performs LWL/LWR merging with the old rt value. It handles one request at a time and tells the issuing control logic when it can take the next one.

## Interface
- `TIMEOUT_CYCLES`, default 0: maximum waitrequest-stalled cycles before abort. 0 means wait forever.
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request offered.
- `req_ready` out 1: stage idle and accepting.
- `req_op` in 4 (`mem_op_t`): LB, LBU, LH, LHU, LW, LWL, LWR, SB, SH, SW.
- `req_addr` in 32: effective byte address from the ALU output.
- `req_wdata` in 32: rt value, used as store data and as the LWL/LWR merge source.
- `req_dest` in 5: destination register tag, passed through.
- `avm_address` out 32: word-aligned address, with bits [1:0] equal to 0.
- `avm_read` / `avm_write` out 1: bus strobes.
- `avm_writedata` out 32: lane-steered store data.
- `avm_byteenable` out 4: active byte lanes.
- `avm_readdata` in 32: read data.
- `avm_waitrequest` in 1: slave stall.
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_data` out 32: load result.
- `resp_dest` out 5: captured destination tag.
- `resp_wen` out 1: register write enable. Set to 1 for a successful load.
- `resp_err` out 1: abort flag, raised on timeout or misalignment.

## Operation
- Byte lane k (k = addr[1:0]) is bits [8k+7:8k], little-endian.
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE:
  - `req_ready` = 1.
  - On `req_valid`, capture op, address, wdata and dest.
  - Go to READ for loads and WRITE for stores, or to RESP if the request is rejected (see Configuration).
- READ and WRITE:
  - The strobe, `avm_address`, `avm_byteenable` and `avm_writedata` are registered and held stable while `avm_waitrequest` = 1.
  - In the cycle where the strobe is 1 and `avm_waitrequest` = 0, the transfer completes. For a read, `avm_readdata` is sampled in that same cycle.
  - The next state is RESP.
- RESP: `resp_valid` = 1 for exactly one cycle, then return to IDLE.
- Byteenable:
  - Byte ops: one-hot on addr[1:0].
  - Halfword ops: 0011 if addr[1] = 0, 1100 if addr[1] = 1.
  - Word ops and LWL/LWR: 1111.
- Stores: the data byte or halfword is replicated into the addressed lanes.
- Loads:
  - The selected lane(s) are right-justified.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW passes the word through.
- LWL, with o = addr[1:0]: result = (mem << 8·(3−o)) | (rt & ((1 << 8·(3−o)) − 1)).
- LWR, with o = addr[1:0]: result = (mem >> 8·o) | (rt & ~(32'hFFFFFFFF >> 8·o)).
- Timeout:
  - A counter runs while the stage is in READ or WRITE with `avm_waitrequest` = 1.
  - If `TIMEOUT_CYCLES` ≠ 0 and the count reaches `TIMEOUT_CYCLES`, the strobe drops and the stage goes to RESP with `resp_err` = 1 and `resp_wen` = 0.
- Stores complete with `resp_wen` = 0.
- `resp_data`, `resp_dest` and `resp_err` hold their values until the next RESP.

## Timing
- Reset values:
  - State = IDLE.
  - `req_ready` = 1.
  - `avm_read`, `avm_write`, `resp_valid`, `resp_wen` and `resp_err` = 0.
  - `avm_address`, `avm_writedata` and `resp_data` = 0.
  - `avm_byteenable` = 0.
  - `resp_dest` = 0.
- Assertion of `reset_n` = 0 clears the strobes immediately, even mid-transaction. The in-flight request is dropped and no `resp_valid` is produced.
- Request accepted in cycle 0: the strobe is high in cycle 1.
- With zero wait states, `resp_valid` fires in cycle 2, and `req_ready` is high again in cycle 3.
- Each waitrequest cycle adds one cycle of latency.
- A rejected request (misaligned) produces `resp_valid` in cycle 1 and issues no bus strobe.
- `req_ready` = 0 in READ, WRITE and RESP. `req_valid` is ignored in those states.

## Configuration
- `MIPS_CPU_MEM_ALIGN_CHECK_EN` defined:
  - Misalignment is defined as addr[0] ≠ 0 for LH/LHU/SH, or addr[1:0] ≠ 0 for LW/SW.
  - A misaligned request is rejected: no bus strobe, RESP with `resp_err` = 1 and `resp_wen` = 0.
- Undefined:
  - The low address bits are ignored for halfword and word ops, i.e. the access is forced to alignment.
  - `resp_err` is raised only by timeout.
- LWL and LWR are never checked.

## Structure
- `mips_cpu_pkg` holds the `mem_op_t` enum, the `mem_state_t` FSM enum, and lane-index constants.
- Sub-module `mips_cpu_load_align` is purely combinational: readdata, op, offset and rt in; write-back word out.
- Store steering and byteenable generation stay in the top module.

## Test plan
- LW at 0x100 with readdata 0xDEADBEEF and no wait → `avm_read` in cycle 1, `avm_address` 0x100, byteenable 1111, `resp_valid` in cycle 2, `resp_data` 0xDEADBEEF, `resp_wen` 1.
- LB at 0x103 with readdata 0x80112233 → byteenable 1000, `resp_data` 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH at 0x202 with wdata 0x0000ABCD and waitrequest high for 3 cycles → `avm_write` held 4 cycles, byteenable 1100, writedata 0xABCDABCD, then `resp_valid` with `resp_wen` 0.
- rt = 0x11223344, readdata 0xAABBCCDD, address 0x301:
  - LWL → 0xCCDD3344.
  - LWR → 0x11AABBCC.
- LW at 0x102:
  - Macro defined → no `avm_read`, `resp_err` 1 in cycle 1.
  - Macro undefined → `avm_address` 0x100 and normal completion.
- Hold waitrequest high, set `TIMEOUT_CYCLES` = 4 → strobe drops after 4 stalled cycles, then `resp_err` 1.
- Separately, drive `reset_n` low mid-stall → strobe 0 immediately, no `resp_valid`.
